// File: rtl/id_stage.sv
// rtl/id_stage.sv - registered RV32I decode stage with forwarding, load-use stall and branch resolution
module id_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter bit              FWD_EN   = 1'b1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs_to_ds_valid,
  input  logic [2*XLEN-1:0] fs_data,
  output logic              ds_allowin,
  input  logic              flush,
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              ex_wen,
  input  logic              mem_wen,
  input  logic              wb_wen,
  input  logic [4:0]        ex_waddr,
  input  logic [4:0]        mem_waddr,
  input  logic [4:0]        wb_waddr,
  input  logic [XLEN-1:0]   ex_wdata,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   wb_wdata,
  input  logic              ex_is_load,
  input  logic              es_allowin,
  output logic              ds_to_es_valid,
  output logic [XLEN-1:0]   es_pc,
  output logic [XLEN-1:0]   es_instr,
  output logic [XLEN-1:0]   es_src1,
  output logic [XLEN-1:0]   es_src2,
  output logic [XLEN-1:0]   es_imm,
  output logic [4:0]        es_rd,
  output logic              es_rf_wen,
  output logic              br_valid,
  output logic [XLEN-1:0]   br_target
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [XLEN-1:0] NOP  = XLEN'(32'h13);

  logic              ds_valid;
  logic [2*XLEN-1:0] ds_buf;
  logic [31:0]       instr;
  logic [XLEN-1:0]   pc;
  logic [6:0]        opcode;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        funct3;
  logic              use_rs1, use_rs2, writes_rd, is_br, is_jal, is_jalr;
  logic [31:0]       imm32;
  logic [XLEN-1:0]   fs1, fs2;
  logic              ex_hit1, ex_hit2, any_hit1, any_hit2, hazard;
  logic              ds_ready_go, issue, cond, taken;

  assign instr  = ds_buf[XLEN+31:XLEN];
  assign pc     = ds_buf[XLEN-1:0];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    is_br     = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    imm32     = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        writes_rd = 1'b1;
        imm32     = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        writes_rd = 1'b1;
        is_jal    = 1'b1;
        imm32     = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_JALR: begin
        writes_rd = 1'b1;
        use_rs1   = 1'b1;
        is_jalr   = 1'b1;
        imm32     = {{21{instr[31]}}, instr[30:20]};
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        is_br   = 1'b1;
        imm32   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LOAD, OP_IMM: begin
        writes_rd = 1'b1;
        use_rs1   = 1'b1;
        imm32     = {{21{instr[31]}}, instr[30:20]};
      end
      OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      end
      OP_REG: begin
        writes_rd = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
      end
      default: ;
    endcase
  end

  // Youngest producer wins; x0 is hard-wired to zero regardless of pending writes.
  function automatic logic [XLEN-1:0] fwd(input logic [4:0] a, input logic [XLEN-1:0] rdata);
    if (a == 5'd0)                       fwd = '0;
    else if (ex_wen && ex_waddr == a)    fwd = ex_wdata;
    else if (mem_wen && mem_waddr == a)  fwd = mem_wdata;
    else if (wb_wen && wb_waddr == a)    fwd = wb_wdata;
    else                                 fwd = rdata;
  endfunction

  assign fs1 = fwd(rs1, rf_rdata1);
  assign fs2 = fwd(rs2, rf_rdata2);

  assign ex_hit1  = use_rs1 && rs1 != 5'd0 && ex_wen && ex_waddr == rs1;
  assign ex_hit2  = use_rs2 && rs2 != 5'd0 && ex_wen && ex_waddr == rs2;
  assign any_hit1 = use_rs1 && rs1 != 5'd0 && ((ex_wen && ex_waddr == rs1) ||
                    (mem_wen && mem_waddr == rs1) || (wb_wen && wb_waddr == rs1));
  assign any_hit2 = use_rs2 && rs2 != 5'd0 && ((ex_wen && ex_waddr == rs2) ||
                    (mem_wen && mem_waddr == rs2) || (wb_wen && wb_waddr == rs2));
  assign hazard   = ds_valid && (((ex_hit1 || ex_hit2) && ex_is_load) ||
                    (!FWD_EN && (any_hit1 || any_hit2)));

  assign ds_ready_go    = !hazard;
  assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid && ds_ready_go;
  assign issue          = ds_valid && ds_ready_go && es_allowin;

  always_comb begin
    case (funct3)
      3'b000:  cond = (fs1 == fs2);
      3'b001:  cond = (fs1 != fs2);
      3'b100:  cond = ($signed(fs1) < $signed(fs2));
      3'b101:  cond = ($signed(fs1) >= $signed(fs2));
      3'b110:  cond = (fs1 < fs2);
      3'b111:  cond = (fs1 >= fs2);
      default: cond = 1'b0;
    endcase
  end

  assign taken     = is_jal || is_jalr || (is_br && cond);
  assign br_valid  = issue && taken && !flush && !rst;
  assign br_target = is_jalr ? ((fs1 + es_imm) & ~XLEN'(1)) : (pc + es_imm);

  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;
  assign es_pc     = pc;
  assign es_instr  = ds_buf[2*XLEN-1:XLEN];
  assign es_imm    = XLEN'($signed(imm32));
  assign es_rd     = rd;
  assign es_rf_wen = writes_rd && rd != 5'd0;
  assign es_src1   = use_rs1 ? fs1 : '0;
  assign es_src2   = (is_jal || is_jalr) ? pc + XLEN'(4) : (use_rs2 ? fs2 : '0);

  // A redirect in this cycle means the packet fetch is offering is wrong-path.
  always_ff @(posedge clk) begin
    if (rst) begin
      ds_valid <= 1'b0;
      ds_buf   <= {NOP, RESET_PC};
    end else if (flush) begin
      ds_valid <= 1'b0;
    end else if (ds_allowin) begin
      ds_valid <= fs_to_ds_valid && !br_valid;
      if (fs_to_ds_valid && !br_valid) ds_buf <= fs_data;
    end
  end
endmodule
